// File: rtl/led_array_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : led_array_scan_driver
// Description : Column-scan driver for an N x N LED array. Each cycle the
//               column selected by x is decoded to a one-hot column strobe and
//               that column's cells are presented on the row drives. Both
//               outputs are registered (one cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module led_array_scan_driver #(
    parameter int N    = 8,
    parameter int ROWS = N,
    parameter int COLS = N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [N*N-1:0]       cells,
    input  logic [$clog2(N):0]   x,
    output logic [ROWS-1:0]      rows,
    output logic [COLS-1:0]      cols
);

    localparam int XW = $clog2(N) + 1;

    // Column masks: mask k selects bit N*j+k of cells for every row j.
    logic [N-1:0][N*N-1:0] w_masks;
    logic [N*N-1:0]        w_sel;
    logic [N-1:0]          w_rows;
    logic [N-1:0]          w_cols;
    logic [ROWS-1:0]       r_rows;
    logic [COLS-1:0]       r_cols;

    generate
        for (genvar k = 0; k < N; k++) begin : g_mask
            for (genvar b = 0; b < N*N; b++) begin : g_bit
                assign w_masks[k][b] = ((b % N) == k) ? 1'b1 : 1'b0;
            end
        end
    endgenerate

    // Pick the mask matching x; out-of-range x or ena=0 leaves nothing selected.
    always_comb begin
        w_sel  = '0;
        w_cols = '0;
        for (int k = 0; k < N; k++) begin
            if (ena && (x == XW'(k))) begin
                w_sel     = cells & w_masks[k];
                w_cols[k] = 1'b1;
            end
        end
    end

    // Each row drive is the OR of the selected cells lying in that row.
    generate
        for (genvar j = 0; j < N; j++) begin : g_row
            assign w_rows[j] = |w_sel[N*j +: N];
        end
    endgenerate

    // Output registers; reset clears the display immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rows <= '0;
            r_cols <= '0;
        end else begin
            r_rows <= w_rows;
            r_cols <= w_cols;
        end
    end

    assign rows = r_rows;
    assign cols = r_cols;

endmodule
`default_nettype wire

// File: tb/tb_led_array_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_array_scan_driver
// Description : Directed self-checking bench for led_array_scan_driver (N=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_array_scan_driver;

    localparam int N  = 8;
    localparam int XW = $clog2(N) + 1;

    logic            clk;
    logic            clk_en;
    logic            rst;
    logic            ena;
    logic [N*N-1:0]  cells;
    logic [XW-1:0]   x;
    logic [N-1:0]    rows;
    logic [N-1:0]    cols;

    int errors;
    int checks;

    led_array_scan_driver #(.N(N), .ROWS(N), .COLS(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .cells (cells),
        .x     (x),
        .rows  (rows),
        .cols  (cols)
    );

    // Gated clock so reset behaviour can be observed with no edges present.
    initial begin
        clk = 1'b0;
        forever begin
            #5 clk = clk_en ? ~clk : 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [N-1:0] er, input logic [N-1:0] ec);
        checks++;
        assert ({rows, cols} === {er, ec})
        else begin
            errors++;
            $error("FAIL %s: rows=%h cols=%h expected rows=%h cols=%h", tag, rows, cols, er, ec);
        end
    endtask

    initial begin
        logic [N*N-1:0] pat;
        logic [N-1:0]   exp_rows;
        logic [N-1:0]   exp_cols;
        int             lit;

        errors = 0;
        checks = 0;
        clk_en = 1'b0;

        // Reset with no clock edge at all.
        rst   = 1'b1;
        ena   = 1'b1;
        cells = '1;
        x     = XW'(3);
        #2;
        check("reset_noclk", 8'h00, 8'h00);

        // First edge after reset release loads column 3.
        rst    = 1'b0;
        clk_en = 1'b1;
        tick();
        check("first_edge", 8'hFF, 8'h08);

        // Reset mid-scan clears at once, clock held.
        clk_en = 1'b0;
        rst    = 1'b1;
        #1;
        check("midscan_reset", 8'h00, 8'h00);
        rst    = 1'b0;
        clk_en = 1'b1;

        // Disabled display.
        ena   = 1'b0;
        cells = '1;
        x     = XW'(2);
        tick();
        check("disable", 8'h00, 8'h00);

        // All on, x changes every cycle.
        ena = 1'b1;
        for (int k = 0; k < N; k++) begin
            x = XW'(k);
            tick();
            exp_cols = '0;
            exp_cols[k] = 1'b1;
            check($sformatf("all_on_x%0d", k), 8'hFF, exp_cols);
        end

        // Out-of-range columns.
        x = XW'(8);
        tick();
        check("oor_x8", 8'h00, 8'h00);
        x = XW'(15);
        tick();
        check("oor_x15", 8'h00, 8'h00);

        // Cells outside the scanned column have no effect.
        pat = '1;
        for (int j = 0; j < N; j++) pat[N*j+3] = 1'b0;
        cells = pat;
        x = XW'(3);
        tick();
        check("other_cols_ignored", 8'h00, 8'h08);

        // Single LED at every position, full column sweep each time.
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                pat = '0;
                pat[N*j+i] = 1'b1;
                cells = pat;
                lit = 0;
                for (int k = 0; k < N; k++) begin
                    x = XW'(k);
                    tick();
                    exp_cols = '0;
                    exp_cols[k] = 1'b1;
                    exp_rows = '0;
                    if (k == i) exp_rows[j] = 1'b1;
                    check($sformatf("single_i%0d_j%0d_x%0d", i, j, k), exp_rows, exp_cols);
                    for (int r = 0; r < N; r++)
                        for (int c = 0; c < N; c++)
                            if (rows[r] === 1'b1 && cols[c] === 1'b1) lit++;
                end
                checks++;
                assert (lit === 1)
                else begin
                    errors++;
                    $error("FAIL single_lit_i%0d_j%0d: lit=%0d expected=1", i, j, lit);
                end
            end
        end

        // Latency: column 2 (rows A5) then column 5 (rows 3C).
        pat = '0;
        for (int j = 0; j < N; j++) begin
            pat[N*j+2] = (8'hA5 >> j) & 1'b1;
            pat[N*j+5] = (8'h3C >> j) & 1'b1;
        end
        cells = pat;
        x = XW'(2);
        tick();
        check("latency_col2", 8'hA5, 8'h04);
        x = XW'(5);
        #3;
        check("latency_hold_col2", 8'hA5, 8'h04);
        // Glitch inputs between edges; only the value at the edge matters.
        ena = 1'b0; x = XW'(9); cells = '1;
        #1;
        check("glitch_no_effect", 8'hA5, 8'h04);
        ena = 1'b1; x = XW'(5); cells = pat;
        tick();
        check("latency_col5", 8'h3C, 8'h20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
